// File: rtl/control_pkg.sv
// Shared definitions for the microcoded control unit: opcodes, micro-step
// encodings and the bit layout of the 16-bit control word.
package control_pkg;

   localparam int STEP_W = 3;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [STEP_W-1:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_t;

   localparam int CW_HLT = 15;
   localparam int CW_MI  = 14;
   localparam int CW_RI  = 13;
   localparam int CW_RO  = 12;
   localparam int CW_IO  = 11;
   localparam int CW_II  = 10;
   localparam int CW_AI  = 9;
   localparam int CW_AO  = 8;
   localparam int CW_EO  = 7;
   localparam int CW_SU  = 6;
   localparam int CW_BI  = 5;
   localparam int CW_OI  = 4;
   localparam int CW_CE  = 3;
   localparam int CW_CO  = 2;
   localparam int CW_J   = 1;
   localparam int CW_FI  = 0;

   typedef logic [15:0] ctrl_word_t;

endpackage

// File: rtl/control_rom.sv
// Combinational microcode decode of opcode/step/flags into the control word
// and a last_step marker. JC/JZ execute only when CONDITIONAL_JUMP_EN is defined.
module control_rom
   import control_pkg::*;
(
   input  logic [3:0] opcode,
   input  step_t      step,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output ctrl_word_t word,
   output logic       last_step
);

`ifndef CONDITIONAL_JUMP_EN
   logic flags_unused_s;
   assign flags_unused_s = carry_flag ^ zero_flag;
`endif

   // Microcode table: fetch at T0/T1, per-opcode execute at T2..T4
   always_comb begin
      word      = 16'h0000;
      last_step = 1'b0;
      case (step)
         T0: begin
            word[CW_CO] = 1'b1;
            word[CW_MI] = 1'b1;
         end
         T1: begin
            word[CW_RO] = 1'b1;
            word[CW_II] = 1'b1;
            word[CW_CE] = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA,
               OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_step = 1'b0;
`ifdef CONDITIONAL_JUMP_EN
               OP_JC, OP_JZ:                   last_step = 1'b0;
`endif
               default:                        last_step = 1'b1;
            endcase
         end
         T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  word[CW_IO] = 1'b1;
                  word[CW_MI] = 1'b1;
               end
               OP_LDI: begin
                  word[CW_IO] = 1'b1;
                  word[CW_AI] = 1'b1;
                  last_step   = 1'b1;
               end
               OP_JMP: begin
                  word[CW_IO] = 1'b1;
                  word[CW_J]  = 1'b1;
                  last_step   = 1'b1;
               end
`ifdef CONDITIONAL_JUMP_EN
               // A not-taken branch leaves T2 empty and still ends here
               OP_JC: begin
                  word[CW_IO] = carry_flag;
                  word[CW_J]  = carry_flag;
                  last_step   = 1'b1;
               end
               OP_JZ: begin
                  word[CW_IO] = zero_flag;
                  word[CW_J]  = zero_flag;
                  last_step   = 1'b1;
               end
`endif
               OP_OUT: begin
                  word[CW_AO] = 1'b1;
                  word[CW_OI] = 1'b1;
                  last_step   = 1'b1;
               end
               OP_HLT: begin
                  word[CW_HLT] = 1'b1;
                  last_step    = 1'b1;
               end
               default: last_step = 1'b1;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  word[CW_RO] = 1'b1;
                  word[CW_AI] = 1'b1;
                  last_step   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  word[CW_RO] = 1'b1;
                  word[CW_BI] = 1'b1;
               end
               OP_STA: begin
                  word[CW_AO] = 1'b1;
                  word[CW_RI] = 1'b1;
                  last_step   = 1'b1;
               end
               default: last_step = 1'b1;
            endcase
         end
         T4: begin
            last_step = 1'b1;
            case (opcode)
               OP_ADD, OP_SUB: begin
                  word[CW_EO] = 1'b1;
                  word[CW_AI] = 1'b1;
                  word[CW_FI] = 1'b1;
                  word[CW_SU] = (opcode == OP_SUB);
               end
               default: word = 16'h0000;
            endcase
         end
         default: last_step = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step counter and halt latch around control_rom; gates the control word
// with reset and halt. Optional conditional jumps: define CONDITIONAL_JUMP_EN.
module control_sequencer
   import control_pkg::*;
#(
   parameter int STEPS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output logic       hlt,
   output logic       mi,
   output logic       ri,
   output logic       ro,
   output logic       io,
   output logic       ii,
   output logic       ai,
   output logic       ao,
   output logic       eo,
   output logic       su,
   output logic       bi,
   output logic       oi,
   output logic       ce,
   output logic       co,
   output logic       j,
   output logic       fi,
   output logic [2:0] step
);

   localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

   step_t      step_r;
   logic       halted_r;
   ctrl_word_t rom_word_s;
   logic       last_step_s;
   ctrl_word_t out_word_s;

   control_rom u_rom (
      .opcode     (opcode),
      .step       (step_r),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .word       (rom_word_s),
      .last_step  (last_step_s)
   );

   // Step counter and halt latch; HLT freezes the step it was decoded in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_r   <= T0;
         halted_r <= 1'b0;
      end else if (halted_r) begin
         step_r   <= step_r;
         halted_r <= 1'b1;
      end else if (rom_word_s[CW_HLT]) begin
         step_r   <= step_r;
         halted_r <= 1'b1;
      end else if (last_step_s || (step_r >= LAST_STEP)) begin
         step_r   <= T0;
         halted_r <= 1'b0;
      end else begin
         step_r   <= step_t'(step_r + 3'd1);
         halted_r <= 1'b0;
      end
   end

   // Reset and halt override the decoded control word
   always_comb begin
      out_word_s = 16'h0000;
      if (rst) begin
         out_word_s = 16'h0000;
      end else if (halted_r) begin
         out_word_s         = 16'h0000;
         out_word_s[CW_HLT] = 1'b1;
      end else begin
         out_word_s = rom_word_s;
      end
   end

   assign hlt  = out_word_s[CW_HLT];
   assign mi   = out_word_s[CW_MI];
   assign ri   = out_word_s[CW_RI];
   assign ro   = out_word_s[CW_RO];
   assign io   = out_word_s[CW_IO];
   assign ii   = out_word_s[CW_II];
   assign ai   = out_word_s[CW_AI];
   assign ao   = out_word_s[CW_AO];
   assign eo   = out_word_s[CW_EO];
   assign su   = out_word_s[CW_SU];
   assign bi   = out_word_s[CW_BI];
   assign oi   = out_word_s[CW_OI];
   assign ce   = out_word_s[CW_CE];
   assign co   = out_word_s[CW_CO];
   assign j    = out_word_s[CW_J];
   assign fi   = out_word_s[CW_FI];
   assign step = step_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction-level reference model,
// directed scenarios and a random opcode stream.
module tb_control_sequencer;

`ifdef CONDITIONAL_JUMP_EN
   localparam bit CJ = 1'b1;
`else
   localparam bit CJ = 1'b0;
`endif

   localparam logic [15:0] M_HLT = 16'h8000;
   localparam logic [15:0] M_MI  = 16'h4000;
   localparam logic [15:0] M_RI  = 16'h2000;
   localparam logic [15:0] M_RO  = 16'h1000;
   localparam logic [15:0] M_IO  = 16'h0800;
   localparam logic [15:0] M_II  = 16'h0400;
   localparam logic [15:0] M_AI  = 16'h0200;
   localparam logic [15:0] M_AO  = 16'h0100;
   localparam logic [15:0] M_EO  = 16'h0080;
   localparam logic [15:0] M_SU  = 16'h0040;
   localparam logic [15:0] M_BI  = 16'h0020;
   localparam logic [15:0] M_OI  = 16'h0010;
   localparam logic [15:0] M_CE  = 16'h0008;
   localparam logic [15:0] M_CO  = 16'h0004;
   localparam logic [15:0] M_J   = 16'h0002;
   localparam logic [15:0] M_FI  = 16'h0001;
   localparam logic [15:0] M_BUS = M_CO | M_RO | M_IO | M_AO | M_EO;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       carry_flag = 1'b0;
   logic       zero_flag = 1'b0;
   logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
   logic [2:0] step;
   logic [15:0] dut_word;

   int n_checks = 0;
   int n_err = 0;

   logic        exp_valid = 1'b0;
   logic [15:0] exp_word = 16'h0000;
   logic [2:0]  exp_step = 3'd0;
   logic [15:0] seen [0:7];
   logic [2:0]  seen_step [0:7];

   control_sequencer #(.STEPS(5)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao), .eo(eo),
      .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi), .step(step)
   );

   assign dut_word = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

   always #5 clk = ~clk;

   // Instruction length in cycles, straight from the opcode table
   function automatic int model_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4:             return 4;
         4'h2, 4'h3:             return 5;
         4'h5, 4'h6, 4'hE, 4'hF: return 3;
         4'h7, 4'h8:             return CJ ? 3 : 2;
         default:                return 2;
      endcase
   endfunction

   // Control word expected at cycle k of an instruction
   function automatic logic [15:0] model_word(input logic [3:0] op, input int k,
                                              input logic c, input logic z);
      logic [15:0] ex [0:2];
      ex[0] = 16'h0000; ex[1] = 16'h0000; ex[2] = 16'h0000;
      if (k == 0) return M_CO | M_MI;
      if (k == 1) return M_RO | M_II | M_CE;
      case (op)
         4'h1: begin ex[0] = M_IO | M_MI; ex[1] = M_RO | M_AI; end
         4'h2: begin ex[0] = M_IO | M_MI; ex[1] = M_RO | M_BI; ex[2] = M_EO | M_AI | M_FI; end
         4'h3: begin ex[0] = M_IO | M_MI; ex[1] = M_RO | M_BI; ex[2] = M_EO | M_AI | M_FI | M_SU; end
         4'h4: begin ex[0] = M_IO | M_MI; ex[1] = M_AO | M_RI; end
         4'h5: ex[0] = M_IO | M_AI;
         4'h6: ex[0] = M_IO | M_J;
         4'h7: ex[0] = (CJ && c) ? (M_IO | M_J) : 16'h0000;
         4'h8: ex[0] = (CJ && z) ? (M_IO | M_J) : 16'h0000;
         4'hE: ex[0] = M_AO | M_OI;
         4'hF: ex[0] = M_HLT;
         default: ex[0] = 16'h0000;
      endcase
      if (k >= 2 && k <= 4) return ex[k-2];
      return 16'h0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Compare process: every mid-cycle, outputs against the model and the bus rule
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_word", {16'h0, dut_word}, 32'h0);
         chk("reset_step", {29'h0, step}, 32'h0);
      end else if (exp_valid) begin
         chk("word", {16'h0, dut_word}, {16'h0, exp_word});
         chk("step", {29'h0, step}, {29'h0, exp_step});
         chk("bus_onehot", {31'h0, ($countones(dut_word & M_BUS) <= 1)}, 32'h1);
      end
   end

   task automatic run_cycles(input logic [3:0] op, input logic c, input logic z, input int n);
      opcode = op; carry_flag = c; zero_flag = z;
      for (int k = 0; k < n; k++) begin
         exp_word = model_word(op, k, c, z);
         exp_step = 3'(k);
         exp_valid = 1'b1;
         @(negedge clk); #1;
         seen[k] = dut_word;
         seen_step[k] = step;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
      run_cycles(op, c, z, model_len(op));
   endtask

   task automatic halted_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         exp_word = M_HLT;
         exp_step = 3'd2;
         exp_valid = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      exp_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_hold_word", {16'h0, dut_word}, 32'h0);
      chk("rst_hold_step", {29'h0, step}, 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] op;
      logic c, z;
      do_reset();

      // LDA after reset
      run_instr(4'h1, 1'b0, 1'b0);
      chk("lda_t0", {16'h0, seen[0]}, 32'h4004);
      chk("lda_t1", {16'h0, seen[1]}, 32'h1408);
      chk("lda_t2", {16'h0, seen[2]}, 32'h4800);
      chk("lda_t3", {16'h0, seen[3]}, 32'h1200);
      chk("lda_steps", {20'h0, seen_step[0], seen_step[1], seen_step[2], seen_step[3]}, 32'h053);
      chk("lda_wrap", {29'h0, step}, 32'h0);

      // SUB: subtract only at T4, then back to T0
      run_instr(4'h3, 1'b0, 1'b0);
      chk("sub_t4", {16'h0, seen[4]}, 32'h02C1);
      chk("sub_t3_nosu", {31'h0, seen[3][6]}, 32'h0);
      chk("sub_after_step", {29'h0, step}, 32'h0);
      chk("sub_after_su", {31'h0, su}, 32'h0);

      // Conditional jumps
      run_instr(4'h7, 1'b1, 1'b0);
      if (CJ) chk("jc_taken_t2", {16'h0, seen[2]}, 32'h0802);
      else    chk("jc_off_len", {29'h0, seen_step[1]}, 32'h1);
      chk("jc_taken_end", {29'h0, step}, 32'h0);
      run_instr(4'h7, 1'b0, 1'b1);
      if (CJ) chk("jc_not_t2", {16'h0, seen[2]}, 32'h0);
      chk("jc_not_end", {29'h0, step}, 32'h0);
      run_instr(4'h8, 1'b0, 1'b1);
      chk("jz_end", {29'h0, step}, 32'h0);

      // HLT freezes for 20 cycles, reset releases
      run_instr(4'hF, 1'b0, 1'b0);
      chk("hlt_t2", {16'h0, seen[2]}, 32'h8000);
      halted_cycles(20);
      chk("hlt_frozen", {13'h0, hlt, dut_word[14:0], step}, {13'h0, 1'b1, 15'h0, 3'd2});
      do_reset();
      chk("hlt_released", {28'h0, hlt, step}, 32'h0);

      // Reset mid-ADD at T3
      run_cycles(4'h2, 1'b0, 1'b0, 3);
      exp_word = M_RO | M_BI; exp_step = 3'd3;
      #2 rst = 1'b1;
      exp_valid = 1'b0;
      #1;
      chk("midrst_word", {16'h0, dut_word}, 32'h0);
      chk("midrst_step", {29'h0, step}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(4'h5, 1'b0, 1'b0);
      chk("midrst_t0", {16'h0, seen[0]}, 32'h4004);

      // Random instruction stream
      for (int n = 0; n < 1000; n++) begin
         op = 4'($urandom_range(0, 15));
         c = 1'($urandom_range(0, 1));
         z = 1'($urandom_range(0, 1));
         run_instr(op, c, z);
         if (op == 4'hF) begin
            halted_cycles(2);
            do_reset();
         end
      end

      exp_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
